// File: rtl/wptr_full_sync_if.sv
// Write-side bus of the async FIFO write-pointer block.
// master: write-side user logic (drives winc, rptr, afull_thresh, clr_err).
// slave : wptr_full_sync (drives pointer and status outputs).
//   winc          write request
//   rptr          Gray read pointer from the rclk domain (asynchronous)
//   afull_thresh  almost-full threshold on free slots
//   clr_err       clears the sticky error flags
//   wptr          registered Gray write pointer
//   waddr         RAM write address
//   wfull         FIFO full
//   wafull        almost full
//   wfree         free slots, 0..DEPTH
//   wovf          sticky overflow
//   wgray_err     sticky illegal Gray step on the synced read pointer
interface wptr_full_sync_if #(
    parameter int ADDRSIZE = 3
);
    logic                winc;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE:0]   afull_thresh;
    logic                clr_err;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE-1:0] waddr;
    logic                wfull;
    logic                wafull;
    logic [ADDRSIZE:0]   wfree;
    logic                wovf;
    logic                wgray_err;

    modport master (
        output winc, rptr, afull_thresh, clr_err,
        input  wptr, waddr, wfull, wafull, wfree, wovf, wgray_err
    );

    modport slave (
        input  winc, rptr, afull_thresh, clr_err,
        output wptr, waddr, wfull, wafull, wfree, wovf, wgray_err
    );
endinterface

// File: rtl/wptr_full_sync.sv
// Write-domain pointer/status block of the async FIFO.
// Synchronizes the Gray read pointer through SYNC_STAGES flops, keeps the
// binary and Gray write pointers, and produces full, almost-full, free-slot
// count and sticky overflow / illegal-Gray-step flags.
// Ports:
//   wclk    write clock
//   wrst_n  asynchronous active-low reset
//   bus     write-side bus (slave): winc, rptr, afull_thresh, clr_err in;
//           wptr, waddr, wfull, wafull, wfree, wovf, wgray_err out
module wptr_full_sync #(
    parameter int ADDRSIZE    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_GRAY  = 1
) (
    input  logic             wclk,
    input  logic             wrst_n,
    wptr_full_sync_if.slave  bus
);
    localparam logic [ADDRSIZE:0] DEPTH = {1'b1, {ADDRSIZE{1'b0}}};

    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b = g;
        for (int unsigned i = 1; i <= ADDRSIZE; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

    logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
    logic [ADDRSIZE:0] wq_rptr;
    logic [ADDRSIZE:0] prev_q;
    logic [ADDRSIZE:0] rbin_s;

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wptr_q;
    logic              wfull_q;
    logic              wafull_q;
    logic [ADDRSIZE:0] wfree_q;
    logic              wovf_q;
    logic              wgray_err_q;

    logic              write_ok;
    logic [ADDRSIZE:0] wbin_next;
    logic [ADDRSIZE:0] wgray_next;
    logic [ADDRSIZE:0] used;
    logic [ADDRSIZE:0] free_next;
    logic              full_next;
    logic              afull_next;
    logic              ovf_evt;
    logic              gray_evt;

    // Read pointer synchronizer chain.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= bus.rptr;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_rptr = sync_q[SYNC_STAGES-1];
    assign rbin_s  = gray2bin(wq_rptr);

    always_comb begin
        write_ok   = bus.winc & ~wfull_q;
        wbin_next  = wbin + {{ADDRSIZE{1'b0}}, write_ok};
        wgray_next = (wbin_next >> 1) ^ wbin_next;
        // Full when the write pointer is one lap ahead: top two Gray bits
        // inverted, remaining bits equal.
        full_next  = (wgray_next == {~wq_rptr[ADDRSIZE:ADDRSIZE-1],
                                     wq_rptr[ADDRSIZE-2:0]});
        used       = wbin_next - rbin_s;
        free_next  = DEPTH - used;
        afull_next = (free_next <= bus.afull_thresh);
        ovf_evt    = bus.winc & wfull_q;
        gray_evt   = (CHECK_GRAY != 0) && ($countones(prev_q ^ wq_rptr) > 1);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin        <= '0;
            wptr_q      <= '0;
            wfull_q     <= 1'b0;
            wafull_q    <= 1'b0;
            wfree_q     <= DEPTH;
            wovf_q      <= 1'b0;
            wgray_err_q <= 1'b0;
            prev_q      <= '0;
        end else begin
            wbin        <= wbin_next;
            wptr_q      <= wgray_next;
            wfull_q     <= full_next;
            wafull_q    <= afull_next;
            wfree_q     <= free_next;
            prev_q      <= wq_rptr;
            // A new error event in the clearing cycle keeps the flag set.
            wovf_q      <= ovf_evt  | (wovf_q      & ~bus.clr_err);
            wgray_err_q <= gray_evt | (wgray_err_q & ~bus.clr_err);
        end
    end

    assign bus.wptr      = wptr_q;
    assign bus.waddr     = wbin[ADDRSIZE-1:0];
    assign bus.wfull     = wfull_q;
    assign bus.wafull    = wafull_q;
    assign bus.wfree     = wfree_q;
    assign bus.wovf      = wovf_q;
    assign bus.wgray_err = wgray_err_q;
endmodule

// File: tb/tb_wptr_full_sync.sv
// Testbench for wptr_full_sync (ADDRSIZE=3, SYNC_STAGES=2, CHECK_GRAY=1).
module tb_wptr_full_sync;
    logic wclk   = 1'b0;
    logic wrst_n = 1'b1;

    always #5 wclk = ~wclk;

    wptr_full_sync_if #(.ADDRSIZE(3)) wif ();

    wptr_full_sync #(
        .ADDRSIZE    (3),
        .SYNC_STAGES (2),
        .CHECK_GRAY  (1)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (wif)
    );

    typedef struct {
        logic [3:0] wptr;
        logic [2:0] waddr;
        logic [3:0] wfree;
        bit         wfull;
        bit         wafull;
        bit         wovf;
        bit         gerr;
    } exp_t;

    typedef struct {
        bit         rst;
        bit         winc;
        logic [3:0] rptr;
        bit         clr;
        logic [3:0] wptr;
        logic [3:0] wfree;
        bit         wfull;
        bit         wafull;
        bit         wovf;
        bit         gerr;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    exp_t sb[$];
    vec_t tab[$];

    // Reference model state
    logic [3:0] m_wcnt;
    int         m_total;
    logic [3:0] m_sync0, m_sync1, m_prev;
    bit         m_full, m_ovf, m_gerr;

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    function automatic vec_t mk(input bit rst, input bit winc, input logic [3:0] rptr,
                                input bit clr, input logic [3:0] wptr, input logic [3:0] wfree,
                                input bit full, input bit afull, input bit ovf, input bit gerr);
        vec_t v;
        v.rst = rst; v.winc = winc; v.rptr = rptr; v.clr = clr;
        v.wptr = wptr; v.wfree = wfree; v.wfull = full; v.wafull = afull;
        v.wovf = ovf; v.gerr = gerr;
        return v;
    endfunction

    function automatic void model_reset();
        m_wcnt = '0; m_total = 0; m_sync0 = '0; m_sync1 = '0; m_prev = '0;
        m_full = 1'b0; m_ovf = 1'b0; m_gerr = 1'b0;
    endfunction

    function automatic exp_t model_step(input bit winc, input logic [3:0] rptr,
                                        input logic [3:0] thr, input bit clr);
        exp_t       e;
        logic [3:0] q, wn, used, free;
        bit         acc, full;
        q    = m_sync1;
        acc  = winc && !m_full;
        wn   = m_wcnt + {3'b000, acc};
        used = wn - g2b(q);
        free = 4'd8 - used;
        full = (used == 4'd8);
        e.wptr   = wn ^ (wn >> 1);
        e.waddr  = wn[2:0];
        e.wfree  = free;
        e.wfull  = full;
        e.wafull = (free <= thr);
        e.wovf   = (winc && m_full) || (m_ovf && !clr);
        e.gerr   = ($countones(m_prev ^ q) > 1) || (m_gerr && !clr);
        m_wcnt  = wn;
        m_total = m_total + (acc ? 1 : 0);
        m_prev  = q;
        m_sync1 = m_sync0;
        m_sync0 = rptr;
        m_full  = full;
        m_ovf   = e.wovf;
        m_gerr  = e.gerr;
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic compare(input string tag, input exp_t e);
        chk({tag, ".wptr"},      int'(wif.wptr),      int'(e.wptr));
        chk({tag, ".waddr"},     int'(wif.waddr),     int'(e.waddr));
        chk({tag, ".wfree"},     int'(wif.wfree),     int'(e.wfree));
        chk({tag, ".wfull"},     int'(wif.wfull),     int'(e.wfull));
        chk({tag, ".wafull"},    int'(wif.wafull),    int'(e.wafull));
        chk({tag, ".wovf"},      int'(wif.wovf),      int'(e.wovf));
        chk({tag, ".wgray_err"}, int'(wif.wgray_err), int'(e.gerr));
    endtask

    // One clock: drive, push expectation, wait edge, pop and compare.
    task automatic step(input bit winc, input logic [3:0] rptr, input logic [3:0] thr,
                        input bit clr, input bit use_tab, input exp_t tab_e, input string tag);
        exp_t me;
        exp_t got;
        wif.winc         = winc;
        wif.rptr         = rptr;
        wif.afull_thresh = thr;
        wif.clr_err      = clr;
        me = model_step(winc, rptr, thr, clr);
        sb.push_back(use_tab ? tab_e : me);
        @(posedge wclk);
        #1;
        got = sb.pop_front();
        compare(tag, got);
    endtask

    task automatic check_reset_values(input string tag);
        exp_t r;
        r.wptr = '0; r.waddr = '0; r.wfree = 4'd8; r.wfull = 0; r.wafull = 0;
        r.wovf = 0; r.gerr = 0;
        compare(tag, r);
    endtask

    task automatic do_reset(input string tag);
        exp_t dummy;
        dummy = '{default: '0};
        wrst_n = 1'b0;
        wif.winc = 1'b0; wif.rptr = '0; wif.afull_thresh = 4'd2; wif.clr_err = 1'b0;
        model_reset();
        #2;
        check_reset_values(tag);
        @(negedge wclk);
        wrst_n = 1'b1;
        step(1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, dummy, {tag, "_release"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t       e;
        exp_t       dummy;
        logic [3:0] b;
        int         rtot;
        logic [3:0] rg;
        logic [3:0] rlow;
        logic [3:0] thr;
        bit         w;

        dummy = '{default: '0};
        wif.winc = 1'b0; wif.rptr = '0; wif.afull_thresh = 4'd2; wif.clr_err = 1'b0;
        #1;
        do_reset("reset0");

        // Fill, overflow, clear, read-pointer release, then Gray jump check.
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0001, 4'd7, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0011, 4'd6, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0010, 4'd5, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0110, 4'd4, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0111, 4'd3, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0101, 4'd2, 0, 1, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0100, 4'd1, 0, 1, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b1100, 4'd0, 1, 1, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b1100, 4'd0, 1, 1, 1, 0));
        tab.push_back(mk(0, 0, 4'b0000, 0, 4'b1100, 4'd0, 1, 1, 1, 0));
        tab.push_back(mk(0, 0, 4'b0000, 1, 4'b1100, 4'd0, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 4'b0010, 0, 4'b1100, 4'd0, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 4'b0010, 0, 4'b1100, 4'd0, 1, 1, 0, 0));
        tab.push_back(mk(0, 0, 4'b0010, 0, 4'b1100, 4'd3, 0, 0, 0, 0));
        tab.push_back(mk(1, 1, 4'b0000, 0, 4'b0001, 4'd7, 0, 0, 0, 0));
        tab.push_back(mk(0, 1, 4'b0000, 0, 4'b0011, 4'd6, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 4'b0011, 0, 4'b0011, 4'd6, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 4'b0011, 0, 4'b0011, 4'd6, 0, 0, 0, 0));
        tab.push_back(mk(0, 0, 4'b0011, 0, 4'b0011, 4'd8, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 4'b0011, 0, 4'b0011, 4'd8, 0, 0, 0, 1));
        tab.push_back(mk(0, 0, 4'b0011, 1, 4'b0011, 4'd8, 0, 0, 0, 0));

        for (int i = 0; i < tab.size(); i++) begin
            if (tab[i].rst) do_reset($sformatf("vec%0d_reset", i));
            b        = g2b(tab[i].wptr);
            e.wptr   = tab[i].wptr;
            e.waddr  = b[2:0];
            e.wfree  = tab[i].wfree;
            e.wfull  = tab[i].wfull;
            e.wafull = tab[i].wafull;
            e.wovf   = tab[i].wovf;
            e.gerr   = tab[i].gerr;
            step(tab[i].winc, tab[i].rptr, 4'd2, tab[i].clr, 1'b1, e, $sformatf("vec%0d", i));
        end

        // Interleaved writes and single-step reads across several wraps.
        do_reset("reset_rand");
        rtot = 0;
        for (int c = 0; c < 600 && m_total < 40; c++) begin
            w = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 2) != 0 && rtot < m_total) rtot++;
            rlow = rtot[3:0];
            rg   = rlow ^ (rlow >> 1);
            thr  = 4'($urandom_range(0, 8));
            step(w, rg, thr, 1'b0, 1'b0, dummy, $sformatf("rand%0d", c));
        end
        chk("rand_write_count", (m_total >= 40) ? 1 : 0, 1);

        // Asynchronous reset in the middle of traffic, checked before any edge.
        wif.winc = 1'b1;
        #1;
        wrst_n = 1'b0;
        #2;
        check_reset_values("midstream_reset");
        @(negedge wclk);
        model_reset();
        wif.winc = 1'b0;
        wrst_n = 1'b1;
        step(1'b0, 4'b0000, 4'd2, 1'b0, 1'b0, dummy, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
